uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_PORTS byte requesters.
// Define UART_TX_ARB_TAG_EN to emit a TAG_BASE+channel byte on every source switch.
module uart_tx_arbiter #(
    parameter int          N_PORTS   = 4,
    parameter int          MAX_BURST = 16,
    parameter logic [7:0]  TAG_BASE  = 8'hF0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_PORTS-1:0]     req,
    input  logic [8*N_PORTS-1:0]   req_data,
    output logic [N_PORTS-1:0]     ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [2:0]             grant_idx
);

    // state     | meaning
    // IDLE      | waiting for any request with the serializer idle
    // ARB       | round-robin pick starting at ptr
    // TAG       | send channel tag byte (tag build only)
    // TAG_WAIT  | wait for the tag byte to finish (tag build only)
    // DATA      | send one data byte from the granted lane, or release
    // DATA_WAIT | wait for the data byte to finish, then burst check
    typedef enum logic [2:0] {
        IDLE,
        ARB,
`ifdef UART_TX_ARB_TAG_EN
        TAG,
        TAG_WAIT,
`endif
        DATA,
        DATA_WAIT
    } state_t;

    localparam int PW = $clog2(N_PORTS);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            wait_first_q, wait_first_d;
    logic [PW-1:0]   pick;
    logic            found;
    logic [PW:0]     scan;
    logic [7:0]      lane;
    logic            other_req;

`ifdef UART_TX_ARB_TAG_EN
    localparam int LW = $clog2(N_PORTS + 1);
    logic [LW-1:0]   last_src_q, last_src_d;
`endif

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
        logic [PW:0] s;
        s = {1'b0, v} + (PW+1)'(1);
        if (s >= (PW+1)'(N_PORTS)) begin
            s = '0;
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N_PORTS)) begin
                scan = scan - (PW+1)'(N_PORTS);
            end
            if (!found && req[scan[PW-1:0]]) begin
                pick  = scan[PW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        lane = 8'h00;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == PW'(i)) begin
                lane = req_data[8*i +: 8];
            end
        end
    end

    assign other_req = |(req & ~(N_PORTS'(1) << grant_q));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        burst_cnt_d  = burst_cnt_q;
        tx_data_d    = tx_data_q;
        wait_first_d = wait_first_q;
        tx_start     = 1'b0;
        ack          = '0;
`ifdef UART_TX_ARB_TAG_EN
        last_src_d   = last_src_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && !tx_busy) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!(|req)) begin
                    state_d = IDLE;
                end else begin
                    grant_d = pick;
`ifdef UART_TX_ARB_TAG_EN
                    state_d = (LW'(pick) != last_src_q) ? TAG : DATA;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            TAG: begin
                tx_start     = 1'b1;
                tx_data_d    = TAG_BASE + 8'(grant_q);
                last_src_d   = LW'(grant_q);
                wait_first_d = 1'b1;
                state_d      = TAG_WAIT;
            end
            TAG_WAIT: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = DATA;
                end
            end
`endif
            DATA: begin
                if (req[grant_q]) begin
                    tx_start     = 1'b1;
                    ack[grant_q] = 1'b1;
                    tx_data_d    = lane;
                    burst_cnt_d  = burst_cnt_q + 8'd1;
                    wait_first_d = 1'b1;
                    state_d      = DATA_WAIT;
                end else begin
                    ptr_d       = inc_mod(grant_q);
                    burst_cnt_d = 8'd0;
                    state_d     = IDLE;
                end
            end
            DATA_WAIT: begin
                // busy only rises the cycle after tx_start, so the first wait cycle is skipped
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = DATA;
                    if (burst_cnt_q == 8'(MAX_BURST)) begin
                        burst_cnt_d = 8'd0;
                        if (other_req) begin
                            ptr_d   = inc_mod(grant_q);
                            state_d = ARB;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data   = tx_data_d;
    assign grant_idx = 3'(grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            burst_cnt_q  <= 8'd0;
            tx_data_q    <= 8'h00;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_data_q    <= tx_data_d;
            wait_first_q <= wait_first_d;
        end
    end

`ifdef UART_TX_ARB_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src_q <= LW'(N_PORTS);
        end else begin
            last_src_q <= last_src_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a busy-cycle uart_tx model and queue-fed requesters.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int MB       = 2;
    localparam int BUSY_CYC = 20;
`ifdef UART_TX_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [2:0]     grant_idx;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_PORTS(N), .MAX_BURST(MB), .TAG_BASE(8'hF0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_idx(grant_idx)
    );

    typedef struct packed {
        logic [7:0]   data;
        logic [N-1:0] ack;
        logic [2:0]   grant;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] lane_q [N][$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic send(input int p, input logic [7:0] b);
        exp_t e;
        lane_q[p].push_back(b);
        e.data  = b;
        e.ack   = N'(1) << p;
        e.grant = 3'(p);
        exp_q.push_back(e);
    endtask

    task automatic expect_tag(input int p);
        exp_t e;
        e.data  = 8'hF0 + 8'(p);
        e.ack   = '0;
        e.grant = 3'(p);
        if (TAG_ON) exp_q.push_back(e);
    endtask

    function automatic bit lanes_busy();
        bit b = 1'b0;
        for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy || lanes_busy()) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got %0d pending want 0", name, exp_q.size());
        end
        repeat (5) @(negedge clk);
    endtask

    // Requesters and uart_tx model: sample at negedge, update just after posedge.
    logic [N-1:0] acked;
    logic         started;
    int           busy_cnt = 0;
    always begin
        @(negedge clk);
        acked   = ack;
        started = tx_start;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else if (started) begin
            tx_busy  = 1'b1;
            busy_cnt = BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acked[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
            req[i] = (lane_q[i].size() != 0);
            req_data[8*i +: 8] = (lane_q[i].size() != 0) ? lane_q[i][0] : 8'h00;
        end
    end

    logic [7:0] last_tx = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (tx_start) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tx: got %02h want no byte", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("ack_on_start", 32'(ack), 32'(e.ack));
                check("grant_idx", 32'(grant_idx), 32'(e.grant));
            end
            last_tx = tx_data;
        end else begin
            check("ack_without_start", 32'(ack), 32'd0);
        end
        if (rst_n && tx_busy && !tx_start) check("tx_data_hold", 32'(tx_data), 32'(last_tx));
    end

    initial begin
        int n;
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fairness: ptr=0, no previous source
        @(negedge clk);
        expect_tag(0); send(0, 8'h10); send(0, 8'h10);
        expect_tag(3); send(3, 8'h30); send(3, 8'h30);
        expect_tag(0); send(0, 8'h10); send(0, 8'h10);
        expect_tag(3); send(3, 8'h30); send(3, 8'h30);
        wait_drain("fairness");

        // single requester: ptr=0, last source 3
        expect_tag(0); send(0, 8'h41); send(0, 8'h42);
        wait_drain("single");

        // source switch
        expect_tag(2); send(2, 8'h55);
        wait_drain("switch_a");
        expect_tag(1); send(1, 8'h66);
        wait_drain("switch_b");

        // same source as last: no tag, 3-cycle latency
        @(negedge clk);
        send(1, 8'h77);
        @(posedge clk);
        #2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        check("latency", 32'(n), 32'd3);
        wait_drain("same_src");

        // long uncontended stream from port 3
        expect_tag(3);
        for (int i = 0; i < 40; i++) send(3, 8'h80 + 8'(i));
        wait_drain("burst");

        // async reset during DATA_WAIT of the first data byte
        expect_tag(2); send(2, 8'hA1);
        lane_q[2].push_back(8'hA2);
        lane_q[2].push_back(8'hA3);
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reset_setup", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_start", 32'(tx_start), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data), 32'd0);
        check("rst_mid_grant", 32'(grant_idx), 32'd0);
        expect_tag(2);
        exp_q.push_back('{data: 8'hA2, ack: N'(1) << 2, grant: 3'd2});
        exp_q.push_back('{data: 8'hA3, ack: N'(1) << 2, grant: 3'd2});
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_drain("after_reset");

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
